// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction FIFO.
package branch_resolve_unit_pkg;

  // Record fields are carried at the widest supported PC width; ADDR_WIDTH must not exceed it.
  localparam int unsigned REC_ADDR_W  = 64;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] pc;
    logic                  taken;
    logic [REC_ADDR_W-1:0] trgt;
  } pred_rec_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Circular FIFO of in-flight prediction records with synchronous clear.
module pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  pred_rec_t                    push_rec_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output pred_rec_t                    head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pred_rec_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_rec_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight branch predictions in order, driving predictor updates,
// mispredict redirects, a saturating mispredict count and a sticky protocol error.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid_i,
  output logic                  pred_ready_o,
  input  logic [ADDR_WIDTH-1:0] pred_pc_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_trgt_i,
  input  logic                  res_valid_i,
  input  logic                  res_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_trgt_i,
  output logic                  upd_valid_o,
  output logic [ADDR_WIDTH-1:0] upd_pc_o,
  output logic                  upd_taken_o,
  output logic [ADDR_WIDTH-1:0] upd_trgt_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  mispred_cnt_o,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  bru_state_e            state_q, state_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d;
  logic                  upd_taken_q, upd_taken_d;
  logic [ADDR_WIDTH-1:0] upd_trgt_q, upd_trgt_d;
  logic                  redirect_q, redirect_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic                  err_q, err_d;

  pred_rec_t     push_rec, head_rec;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          run, push, pop, mispredict;

  assign push_rec = '{pc: REC_ADDR_W'(pred_pc_i), taken: pred_taken_i,
                      trgt: REC_ADDR_W'(pred_trgt_i)};

  assign run          = (state_q == RUN);
  assign pred_ready_o = run && (fifo_count < CW'(DEPTH));
  assign pop          = res_valid_i && run && !fifo_empty;
  assign mispredict   = pop && ((res_taken_i != head_rec.taken) ||
                        (res_taken_i && (REC_ADDR_W'(res_trgt_i) != head_rec.trgt)));
  // A same-cycle enqueue is dropped along with the flushed younger records.
  assign push         = pred_valid_i && pred_ready_o && !mispredict;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_rec_i (push_rec),
    .pop_i      (pop),
    .clear_i    (mispredict),
    .head_o     (head_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    upd_valid_d   = pop;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    upd_trgt_d    = upd_trgt_q;
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    mispred_cnt_d = mispred_cnt_q;
    // Any resolve that cannot pop is a protocol violation.
    err_d         = err_q || (res_valid_i && !pop);
    if (pop) begin
      upd_pc_d      = ADDR_WIDTH'(head_rec.pc);
      upd_taken_d   = res_taken_i;
      upd_trgt_d    = res_trgt_i;
      redirect_pc_d = res_taken_i ? res_trgt_i
                                  : ADDR_WIDTH'(head_rec.pc + REC_ADDR_W'(INSTR_BYTES));
    end
    if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    case (state_q)
      RUN:     if (mispredict) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_trgt_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mispred_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_trgt_q    <= upd_trgt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mispred_cnt_q <= mispred_cnt_d;
      err_q         <= err_d;
    end
  end

  assign upd_valid_o   = upd_valid_q;
  assign upd_pc_o      = upd_pc_q;
  assign upd_taken_o   = upd_taken_q;
  assign upd_trgt_o    = upd_trgt_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign mispred_cnt_o = mispred_cnt_q;
  assign err_o         = err_q;

  full_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CW'(DEPTH)));

endmodule
